// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver
//
// Recovers one byte per frame from the asynchronous serial line and hands it
// to the consuming logic with a single-cycle strobe. Every bit is sampled at
// its middle: the start bit is re-checked half a bit after the falling edge,
// and each later bit one full bit period after the previous sample. A stop
// bit sampled low is reported as a framing error, and the byte is dropped.
//
// Parameters
//   BAUD       line bit rate in bits/s
//   F          clk frequency in Hz
//
// Ports
//   clk        in   1  system clock, all logic on the rising edge
//   rst        in   1  asynchronous reset, active low
//   rx         in   1  serial line, idle high, asynchronous to clk
//   data       out  8  last correctly framed byte, held until the next good frame
//   valid      out  1  one-cycle pulse when data is updated
//   frame_err  out  1  one-cycle pulse when a stop bit is sampled low
//   busy       out  1  high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS = F / BAUD;
  localparam int HALF = CLKS / 2;
  localparam int CW   = (CLKS > 1) ? $clog2(CLKS) : 1;

  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

  typedef enum logic [1:0] {
    START = 2'b00,
    DATA  = 2'b01,
    STOP  = 2'b10,
    IDLE  = 2'b11
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sreg;

  logic          rx_meta;
  logic          rs;
  logic          rs_d;

  // Two-flop synchronizer plus one delay stage for edge detection. These
  // reset to 1 (idle line) so that releasing reset never looks like a start
  // edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
      rs_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
      rs_d    <= rs;
    end
  end

  // Receive state machine. valid and frame_err default low every cycle, so
  // each is a single-cycle pulse. The machine leaves STOP at the middle of
  // the stop bit, so the start edge of a back-to-back frame is still seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sreg      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          // Only a genuine 1->0 transition arms; a line stuck low (break)
          // must return high first.
          if (rs_d && !rs) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == CNT_HALF_END) begin
            cnt <= '0;
            // Line back high at mid start bit means a glitch, not a frame.
            if (!rs) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_BIT_END) begin
            cnt  <= '0;
            // LSB arrives first, so shifting right leaves bit 0 at sreg[0]
            // after the eighth sample.
            sreg <= {rs, sreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == CNT_BIT_END) begin
            cnt   <= '0;
            state <= IDLE;
            if (rs) begin
              data  <= sreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // busy is a pure decode of the state register.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 115200 baud / 50 MHz
// (434 clocks per bit). A table of single frames is applied in a loop, then
// hand-written sequences cover back-to-back frames, a start glitch, a
// framing error followed by a break, and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLKS = 434;
  localparam int HALF = 217;
  // 2 sync flops + 1 edge-detect cycle + half a bit + 9 full bits
  localparam int LAT  = 2 + 1 + HALF + 9 * CLKS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.BAUD(115200), .F(50000000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Free-running cycle counter used to timestamp strobes.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge away from the active edge.
  int         n_valid        = 0;
  int         n_ferr         = 0;
  int         n_both         = 0;
  int         busy_cycles    = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  logic [7:0] log_q[$];

  always @(negedge clk) begin
    if (valid) begin
      n_valid        <= n_valid + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
      log_q.push_back(data);
    end
    if (frame_err)          n_ferr      <= n_ferr + 1;
    if (valid && frame_err) n_both      <= n_both + 1;
    if (busy)               busy_cycles <= busy_cycles + 1;
  end

  typedef struct {
    string      name;
    logic [7:0] tx_byte;
    logic       stop_bit;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    total++;
    if (actual < lo || actual > hi) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clks(CLKS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic applyStimulus(input vec_t v);
    int nv0, nf0, t0;
    nv0 = n_valid;
    nf0 = n_ferr;
    send_frame(v.tx_byte, v.stop_bit, t0);
    rx = 1'b1;
    wait_clks(CLKS);
    checkOutput({v.name, "_data"},  int'(data),    int'(v.exp_data));
    checkOutput({v.name, "_valid"}, n_valid - nv0, v.exp_valid);
    checkOutput({v.name, "_ferr"},  n_ferr - nf0,  v.exp_ferr);
    if (v.exp_valid == 1)
      checkRange({v.name, "_latency"}, last_valid_cyc - t0, LAT - 1, LAT + 1);
  endtask

  initial begin
    int nv0, nf0, b0, t0, qs;

    vecs[0] = '{"v_d3", 8'hD3, 1'b1, 8'hD3, 1, 0};
    vecs[1] = '{"v_55", 8'h55, 1'b1, 8'h55, 1, 0};
    vecs[2] = '{"v_a0_badstop", 8'hA0, 1'b0, 8'h55, 0, 1};
    vecs[3] = '{"v_01", 8'h01, 1'b1, 8'h01, 1, 0};

    // Reset state, both while held and after release.
    rst = 1'b0;
    rx  = 1'b1;
    wait_clks(5);
    checkOutput("rst_hold_data",  int'(data),      0);
    checkOutput("rst_hold_valid", int'(valid),     0);
    checkOutput("rst_hold_ferr",  int'(frame_err), 0);
    checkOutput("rst_hold_busy",  int'(busy),      0);
    rst = 1'b1;
    wait_clks(3);
    checkOutput("rst_rel_data",  int'(data),      0);
    checkOutput("rst_rel_valid", n_valid,         0);
    checkOutput("rst_rel_ferr",  n_ferr,          0);
    checkOutput("rst_rel_busy",  int'(busy),      0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Back-to-back frames with no idle bits between them.
    nv0 = n_valid;
    send_frame(8'h2C, 1'b1, t0);
    send_frame(8'h93, 1'b1, t0);
    rx = 1'b1;
    wait_clks(CLKS);
    qs = log_q.size();
    checkOutput("b2b_valid_count", n_valid - nv0, 2);
    checkOutput("b2b_first",  (qs >= 2) ? int'(log_q[qs-2]) : -1, 8'h2C);
    checkOutput("b2b_second", (qs >= 1) ? int'(log_q[qs-1]) : -1, 8'h93);
    checkRange("b2b_gap", last_valid_cyc - prev_valid_cyc, 10 * CLKS - 1, 10 * CLKS + 1);

    // Short low glitch: start bit rejected at its midpoint, so busy stays
    // high for half a bit and no strobe appears.
    nv0 = n_valid;
    nf0 = n_ferr;
    b0  = busy_cycles;
    rx  = 1'b0;
    wait_clks(100);
    rx  = 1'b1;
    wait_clks(CLKS);
    checkOutput("glitch_valid", n_valid - nv0, 0);
    checkOutput("glitch_ferr",  n_ferr - nf0,  0);
    checkOutput("glitch_data",  int'(data),    8'h93);
    checkRange("glitch_busy", busy_cycles - b0, HALF - 2, HALF + 2);

    // 0xFF with a low stop bit, then the line held low (break).
    nv0 = n_valid;
    nf0 = n_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b0);
    b0 = busy_cycles;
    wait_clks(3000);
    checkOutput("break_ferr",  n_ferr - nf0,     1);
    checkOutput("break_valid", n_valid - nv0,    0);
    checkOutput("break_data",  int'(data),       8'h93);
    checkOutput("break_busy",  busy_cycles - b0, 0);
    rx = 1'b1;
    wait_clks(CLKS);
    nv0 = n_valid;
    send_frame(8'hEF, 1'b1, t0);
    rx = 1'b1;
    wait_clks(CLKS);
    checkOutput("after_break_data",  int'(data),   8'hEF);
    checkOutput("after_break_valid", n_valid - nv0, 1);

    // Reset asserted during bit 4 of 0x9B.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b_9b(i));
    rx = b_9b(4);
    wait_clks(200);
    rst = 1'b0;
    #1;
    checkOutput("midrst_data",  int'(data),      0);
    checkOutput("midrst_valid", int'(valid),     0);
    checkOutput("midrst_ferr",  int'(frame_err), 0);
    checkOutput("midrst_busy",  int'(busy),      0);
    rx = 1'b1;
    wait_clks(5);
    rst = 1'b1;
    wait_clks(CLKS);
    nv0 = n_valid;
    nf0 = n_ferr;
    send_frame(8'hD9, 1'b1, t0);
    rx = 1'b1;
    wait_clks(CLKS);
    checkOutput("post_rst_data",  int'(data),    8'hD9);
    checkOutput("post_rst_valid", n_valid - nv0, 1);
    checkOutput("post_rst_ferr",  n_ferr - nf0,  0);
    checkRange("post_rst_latency", last_valid_cyc - t0, LAT - 1, LAT + 1);

    checkOutput("valid_ferr_overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic b_9b(input int i);
    logic [7:0] v;
    v = 8'h9B;
    return v[i];
  endfunction

endmodule
